// File: rtl/lagd_fifo_sched_pkg.sv
// lagd_fifo_sched shared types
// FSM encoding and default sizes
package lagd_fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } sched_state_e;

  localparam int unsigned NumReqDefault   = 4;
  localparam int unsigned CntWidthDefault = 16;

endpackage

// File: rtl/lagd_rr_arbiter.sv
// Round-robin arbiter with pointer register
// Search starts at the requester after the last winner
module lagd_rr_arbiter
  import lagd_fifo_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NumReqDefault,
  localparam int unsigned IdW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               gnt_en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     gnt_id_o,
  output logic               gnt_valid_o
);

  logic [IdW-1:0] ptr_q;

  function automatic logic [IdW-1:0] wrap_idx(
    input logic [IdW-1:0] base,
    input int unsigned    off
  );
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IdW'(s);
  endfunction

  // first valid requester at or after the pointer
  always_comb begin
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    if (gnt_en_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_valid_o && req_i[wrap_idx(ptr_q, i)]) begin
          gnt_valid_o = 1'b1;
          gnt_id_o    = wrap_idx(ptr_q, i);
        end
      end
      if (gnt_valid_o) gnt_o = NUM_REQ'(1) << gnt_id_o;
    end
  end

  // pointer moves past the winner on each accepted grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
    end else if (gnt_valid_o) begin
      if (gnt_id_o == IdW'(NUM_REQ - 1)) ptr_q <= '0;
      else ptr_q <= gnt_id_o + 1'b1;
    end
  end

endmodule

// File: rtl/lagd_fifo_sched.sv
// Push arbiter and read stream in front of one FIFO
// Also sequences enable, drain and flush
module lagd_fifo_sched
  import lagd_fifo_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = NumReqDefault,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned CNT_WIDTH  = CntWidthDefault,
  localparam int unsigned REQ_ID_W   =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          flush_req_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_skip_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [REQ_ID_W-1:0]           grant_id_o,
  output logic                          fifo_push_o,
  output logic                          fifo_push_none_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]         fifo_data_i,
  output logic                          fifo_pop_o,
  output logic                          fifo_flush_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  input  logic                          out_ready_i,
  output logic [1:0]                    state_o,
  output logic [CNT_WIDTH-1:0]          push_cnt_o,
  output logic [CNT_WIDTH-1:0]          skip_cnt_o
);

  sched_state_e          state_q;
  logic                  gnt_en;
  logic                  gnt_valid;
  logic [NUM_REQ-1:0]    gnt;
  logic [REQ_ID_W-1:0]   gnt_id;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // full is independent of pop in a non-fall-through FIFO
  assign gnt_en = (state_q == RUN) & ~fifo_full_i;

  lagd_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (state_q == FLUSH),
    .req_i       (req_valid_i),
    .gnt_en_i    (gnt_en),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  assign req_ready_o = gnt;
  assign grant_id_o  = gnt_id;
  assign fifo_push_o = gnt_valid;

  // steer the winner's data and skip flag to the FIFO
  always_comb begin
    fifo_data_o      = '0;
    fifo_push_none_o = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        fifo_data_o      = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        fifo_push_none_o = req_skip_i[k];
      end
    end
  end

  assign out_valid_o  = ~fifo_empty_i &
                        ((state_q == RUN) | (state_q == DRAIN));
  assign out_data_o   = fifo_data_i;
  assign fifo_pop_o   = out_valid_o & out_ready_i;
  assign fifo_flush_o = (state_q == FLUSH);
  assign state_o      = state_q;

  // run-control FSM, flush request has priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (flush_req_i && state_q != FLUSH) begin
      state_q <= FLUSH;
    end else begin
      unique case (state_q)
        IDLE:  if (en_i) state_q <= RUN;
        RUN:   if (!en_i) state_q <= DRAIN;
        DRAIN: begin
          if (fifo_empty_i) state_q <= IDLE;
          else if (en_i) state_q <= RUN;
        end
        FLUSH: state_q <= IDLE;
      endcase
    end
  end

  // saturating push/skip statistics, cleared by flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      push_cnt_o <= '0;
      skip_cnt_o <= '0;
    end else if (state_q == FLUSH) begin
      push_cnt_o <= '0;
      skip_cnt_o <= '0;
    end else if (gnt_valid) begin
      push_cnt_o <= sat_inc(push_cnt_o);
      if (fifo_push_none_o) skip_cnt_o <= sat_inc(skip_cnt_o);
    end
  end

endmodule

// File: tb/tb_lagd_fifo_sched.sv
// lagd_fifo_sched bench with a depth-4 FIFO model
// Scoreboard queue tracks words expected on the read stream
module tb_lagd_fifo_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         flush_req;
  logic [3:0]   req_valid;
  logic [3:0]   req_skip;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [1:0]   grant_id;
  logic         fifo_push;
  logic         fifo_push_none;
  logic [31:0]  fifo_wdata;
  logic         fifo_full;
  logic         fifo_empty;
  logic [31:0]  fifo_rdata;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_ready;
  logic [1:0]   state;
  logic [15:0]  push_cnt;
  logic [15:0]  skip_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  lagd_fifo_sched #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .en_i             (en),
    .flush_req_i      (flush_req),
    .req_valid_i      (req_valid),
    .req_skip_i       (req_skip),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .grant_id_o       (grant_id),
    .fifo_push_o      (fifo_push),
    .fifo_push_none_o (fifo_push_none),
    .fifo_data_o      (fifo_wdata),
    .fifo_full_i      (fifo_full),
    .fifo_empty_i     (fifo_empty),
    .fifo_data_i      (fifo_rdata),
    .fifo_pop_o       (fifo_pop),
    .fifo_flush_o     (fifo_flush),
    .out_valid_o      (out_valid),
    .out_data_o       (out_data),
    .out_ready_i      (out_ready),
    .state_o          (state),
    .push_cnt_o       (push_cnt),
    .skip_cnt_o       (skip_cnt)
  );

  // non-fall-through FIFO model, DEPTH=4
  logic [31:0] mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  usage;
  logic        push_ok, pop_ok;

  assign fifo_full  = (usage == 3'd4);
  assign fifo_empty = (usage == 3'd0);
  assign fifo_rdata = mem[rp];
  assign push_ok    = fifo_push & ~fifo_full;
  assign pop_ok     = fifo_pop & ~fifo_empty;

  always @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      usage <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (fifo_flush) begin
      wp    <= '0;
      rp    <= '0;
      usage <= '0;
    end else begin
      if (push_ok) begin
        if (!fifo_push_none) mem[wp] <= fifo_wdata;
        wp <= wp + 2'd1;
      end
      if (pop_ok) rp <= rp + 2'd1;
      usage <= usage + 3'(push_ok) - 3'(pop_ok);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int k = 0; k < 4; k++)
      req_data[k*32 +: 32] = base + 32'(k);
  endtask

  // gid<0 means no grant expected; vexp is expected out_valid
  task automatic cyc_chk(input int gid,
                         input logic skip,
                         input logic vexp);
    logic [31:0] d;
    #1;
    if (gid >= 0) begin
      d = req_data[gid*32 +: 32];
      chk("ready", 32'(req_ready), 32'(1) << gid);
      chk("grant_id", 32'(grant_id), 32'(gid));
      chk("push", 32'(fifo_push), 32'd1);
      chk("push_none", 32'(fifo_push_none), 32'(skip));
      chk("wdata", fifo_wdata, d);
    end else begin
      d = '0;
      chk("ready_idle", 32'(req_ready), 32'd0);
      chk("push_idle", 32'(fifo_push), 32'd0);
      chk("none_idle", 32'(fifo_push_none), 32'd0);
    end
    chk("out_valid", 32'(out_valid), 32'(vexp));
    chk("pop", 32'(fifo_pop), 32'(vexp & out_ready));
    if (vexp && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_underflow observed=%0h expected=none",
               out_data);
      end else begin
        chk("rdata", out_data, q.pop_front());
      end
    end
    if (gid >= 0) q.push_back(skip ? mem[wp] : d);
  endtask

  logic [1:0]  s_slot;
  logic [31:0] s_word;
  logic [2:0]  s_use;

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    flush_req = 1'b0;
    req_valid = '0;
    req_skip  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_push_cnt", 32'(push_cnt), 32'd0);
    chk("rst_skip_cnt", 32'(skip_cnt), 32'd0);
    chk("rst_flush", 32'(fifo_flush), 32'd0);
    cyc_chk(-1, 1'b0, 1'b0);

    // 1: round-robin over four always-valid requesters
    step();
    en        = 1'b1;
    req_valid = 4'b1111;
    set_data(32'hA0);
    out_ready = 1'b1;
    chk("idle_state", 32'(state), 32'd0);
    cyc_chk(-1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      cyc_chk(c % 4, 1'b0, c > 0);
    end
    step();
    req_valid = '0;
    cyc_chk(-1, 1'b0, 1'b1);
    chk("rr_push_cnt", 32'(push_cnt), 32'd6);

    // 2: skip push from requester 2
    step();
    req_valid = 4'b0100;
    req_skip  = 4'b0100;
    req_data[2*32 +: 32] = 32'hDEADBEEF;
    out_ready = 1'b0;
    s_slot = wp;
    s_word = mem[wp];
    s_use  = usage;
    cyc_chk(2, 1'b1, 1'b0);
    step();
    req_valid = '0;
    req_skip  = '0;
    cyc_chk(-1, 1'b0, 1'b1);
    chk("skip_cnt", 32'(skip_cnt), 32'd1);
    chk("skip_push_cnt", 32'(push_cnt), 32'd7);
    chk("skip_mem", mem[s_slot], s_word);
    chk("skip_usage", 32'(usage), 32'(s_use) + 32'd1);

    // 3: fill to full, stall, one pop, grant again
    step();
    req_valid = 4'b1111;
    set_data(32'hB0);
    cyc_chk(3, 1'b0, 1'b1);
    step();
    cyc_chk(0, 1'b0, 1'b1);
    step();
    cyc_chk(1, 1'b0, 1'b1);
    step();
    chk("full", 32'(fifo_full), 32'd1);
    cyc_chk(-1, 1'b0, 1'b1);
    step();
    cyc_chk(-1, 1'b0, 1'b1);
    step();
    out_ready = 1'b1;
    cyc_chk(-1, 1'b0, 1'b1);
    step();
    out_ready = 1'b0;
    cyc_chk(2, 1'b0, 1'b1);

    // 4: drain three entries with en low
    step();
    req_valid = '0;
    out_ready = 1'b1;
    cyc_chk(-1, 1'b0, 1'b1);
    step();
    en        = 1'b0;
    out_ready = 1'b0;
    chk("pre_drain", 32'(state), 32'd1);
    cyc_chk(-1, 1'b0, 1'b1);
    step();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      chk("drain_state", 32'(state), 32'd2);
      cyc_chk(-1, 1'b0, 1'b1);
    end
    step();
    chk("drain_empty", 32'(state), 32'd2);
    cyc_chk(-1, 1'b0, 1'b0);
    step();
    chk("drain_idle", 32'(state), 32'd0);
    cyc_chk(-1, 1'b0, 1'b0);
    chk("hold_push_cnt", 32'(push_cnt), 32'd11);
    chk("hold_skip_cnt", 32'(skip_cnt), 32'd1);

    // 5: flush, refill to rr_ptr=2 / 5,1, flush again
    step();
    req_valid = '0;
    flush_req = 1'b1;
    out_ready = 1'b0;
    chk("f0_flush", 32'(fifo_flush), 32'd0);
    step();
    flush_req = 1'b0;
    req_valid = 4'b1111;
    chk("f0_state", 32'(state), 32'd3);
    chk("f0_flush_o", 32'(fifo_flush), 32'd1);
    cyc_chk(-1, 1'b0, 1'b0);
    q.delete();
    step();
    en        = 1'b1;
    req_valid = '0;
    chk("f0_idle", 32'(state), 32'd0);
    chk("f0_push_cnt", 32'(push_cnt), 32'd0);
    chk("f0_skip_cnt", 32'(skip_cnt), 32'd0);
    step();
    req_valid = 4'b1111;
    req_skip  = 4'b1000;
    set_data(32'hC0);
    out_ready = 1'b1;
    chk("f1_run", 32'(state), 32'd1);
    cyc_chk(0, 1'b0, 1'b0);
    step();
    cyc_chk(1, 1'b0, 1'b1);
    step();
    cyc_chk(2, 1'b0, 1'b1);
    step();
    cyc_chk(3, 1'b1, 1'b1);
    step();
    req_valid = 4'b0010;
    req_skip  = '0;
    cyc_chk(1, 1'b0, 1'b1);
    step();
    req_valid = '0;
    flush_req = 1'b1;
    chk("f1_push_cnt", 32'(push_cnt), 32'd5);
    chk("f1_skip_cnt", 32'(skip_cnt), 32'd1);
    cyc_chk(-1, 1'b0, 1'b1);
    step();
    flush_req = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b0;
    chk("f1_state", 32'(state), 32'd3);
    chk("f1_flush_o", 32'(fifo_flush), 32'd1);
    cyc_chk(-1, 1'b0, 1'b0);
    q.delete();
    step();
    chk("f1_idle", 32'(state), 32'd0);
    chk("f1_flush_lo", 32'(fifo_flush), 32'd0);
    chk("f1_clr_push", 32'(push_cnt), 32'd0);
    chk("f1_clr_skip", 32'(skip_cnt), 32'd0);
    cyc_chk(-1, 1'b0, 1'b0);
    step();
    cyc_chk(0, 1'b0, 1'b0);

    // 6: reset in the middle of a push
    step();
    rst = 1'b1;
    cyc_chk(1, 1'b0, 1'b1);
    q.delete();
    step();
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_push", 32'(fifo_push), 32'd0);
    chk("mrst_none", 32'(fifo_push_none), 32'd0);
    chk("mrst_wdata", fifo_wdata, 32'd0);
    chk("mrst_gid", 32'(grant_id), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_pop", 32'(fifo_pop), 32'd0);
    chk("mrst_flush", 32'(fifo_flush), 32'd0);
    chk("mrst_push_cnt", 32'(push_cnt), 32'd0);
    chk("mrst_skip_cnt", 32'(skip_cnt), 32'd0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lagd_fifo_sched.md
Name: lagd_fifo_sched

Overview:
- Scheduler in front of one lagd_fifo_v3 instance in the flip manager.
- Shares the FIFO push port between NUM_REQ producers using round-robin arbitration.
- Turns producer "skip" requests into push_none pushes, which advance the FIFO pointers without writing data.
- Presents the FIFO read side as a valid/ready stream and sequences enable, drain and flush of the FIFO.

Parameters:
- NUM_REQ, 4, number of push requesters (>=1).
- DATA_WIDTH, 32, FIFO word width.
- CNT_WIDTH, 16, width of the accepted-push and skip statistics counters.
- REQ_ID_W, derived: NUM_REQ>1 ? $clog2(NUM_REQ) : 1, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  run enable.
- flush_req_i  in  1  request a FIFO flush.
- req_valid_i  in  NUM_REQ  per-requester push valid.
- req_skip_i  in  NUM_REQ  push as push_none (no write).
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester data, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  out  NUM_REQ  one-hot accept.
- grant_id_o  out  REQ_ID_W  index of the accepted requester (valid when fifo_push_o).
- fifo_push_o  out  1  to FIFO push_i.
- fifo_push_none_o  out  1  to FIFO push_none_i.
- fifo_data_o  out  DATA_WIDTH  to FIFO data_i.
- fifo_full_i  in  1  FIFO full_o.
- fifo_empty_i  in  1  FIFO empty_o.
- fifo_data_i  in  DATA_WIDTH  FIFO data_o.
- fifo_pop_o  out  1  to FIFO pop_i.
- fifo_flush_o  out  1  to FIFO flush_i.
- out_valid_o  out  1  read-stream valid.
- out_data_o  out  DATA_WIDTH  read-stream data.
- out_ready_i  in  1  read-stream ready.
- state_o  out  2  current FSM state.
- push_cnt_o  out  CNT_WIDTH  accepted pushes since the last flush.
- skip_cnt_o  out  CNT_WIDTH  accepted skip pushes since the last flush.

Behaviour:
- FSM states: IDLE=0, RUN=1, DRAIN=2, FLUSH=3.
- Reset (rst_i high at a clock edge) puts every register in its reset state: state IDLE, rr_ptr 0, push_cnt_o 0, skip_cnt_o 0. All combinational outputs are therefore 0.
- rst_i applied mid-operation aborts any in-flight push or pop on that edge.
- Transitions are evaluated in priority order:
  - flush_req_i in any state other than FLUSH -> FLUSH.
  - IDLE with en_i high -> RUN.
  - RUN with en_i low -> DRAIN.
  - DRAIN with fifo_empty_i high -> IDLE.
  - DRAIN with en_i high -> RUN.
  - FLUSH -> IDLE unconditionally after one cycle.
- fifo_flush_o = (state == FLUSH), Moore output, exactly one cycle wide. In FLUSH, all grants and pops are suppressed.
- Arbitration (combinational, zero latency):
  - Active only in RUN with fifo_full_i low.
  - Grant the first requester with req_valid_i set, searching from rr_ptr upward and wrapping at NUM_REQ-1 -> 0.
  - On a grant: req_ready_o[g]=1, grant_id_o=g, fifo_push_o=1, fifo_push_none_o=req_skip_i[g], fifo_data_o=req_data_i[g].
  - With no grant: req_ready_o=0, fifo_push_o=0, fifo_push_none_o=0, fifo_data_o=0, grant_id_o=0.
  - rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1 on each accepted push. rr_ptr is unchanged otherwise.
  - rr_ptr resets to 0 in FLUSH.
- A requester must hold valid, skip and data stable until it sees ready. The scheduler does not check this.
- Read side:
  - out_valid_o = ~fifo_empty_i & (state==RUN | state==DRAIN).
  - out_data_o = fifo_data_i.
  - fifo_pop_o = out_valid_o & out_ready_i.
  - A push and a pop in the same cycle are both allowed.
- Full/empty boundaries:
  - With fifo_full_i high, no grant is issued, even if a pop happens in the same cycle. The FIFO is non-fall-through, so full_o does not depend on pop_i.
  - With fifo_empty_i high, no pop is issued.
- The FIFO is instantiated with FALL_THROUGH=0 and the same DATA_WIDTH.
- Counters:
  - push_cnt_o increments on each accepted push.
  - skip_cnt_o increments on each accepted push that has fifo_push_none_o high.
  - Both saturate at all-ones.
  - Both clear in FLUSH.
  - Both hold in IDLE and DRAIN.

Decomposition:
- Package lagd_fifo_sched_pkg holds:
  - sched_state_e: 2-bit enum IDLE/RUN/DRAIN/FLUSH.
  - Default constants NumReqDefault=4 and CntWidthDefault=16.
- Sub-module lagd_rr_arbiter holds the round-robin grant logic and the rr_ptr register.
  - Parameter: NUM_REQ.
  - Ports: clk_i, rst_i, clear_i, req_i, gnt_en_i, gnt_o (one-hot), gnt_id_o, gnt_valid_o.
  - It updates its pointer when gnt_valid_o & gnt_en_i.

Test Plan:
1. Reset then en_i=1 with all 4 requesters valid continuously and the FIFO never full -> grants 0,1,2,3,0,1 on consecutive cycles; push_cnt_o=6 after 6 cycles.
2. Requester 2 valid with req_skip_i=1 and data 0xDEADBEEF -> fifo_push_o=1, fifo_push_none_o=1; skip_cnt_o=1; FIFO memory word unchanged while FIFO usage increments.
3. FIFO (DEPTH=4) filled by 4 pushes, then out_ready_i=0 -> fifo_full_i=1 and req_ready_o=0000 for all following cycles. Raise out_ready_i for 1 cycle -> one pop, and the next cycle grants again.
4. en_i drops with 3 entries queued -> state DRAIN, no grants, 3 pops with out_ready_i=1, then IDLE on the cycle after fifo_empty_i rises.
5. flush_req_i pulse in RUN with rr_ptr=2 and counts 5/1 -> one cycle with state FLUSH and fifo_flush_o=1; then IDLE, counts 0/0, and the next grant comes from requester 0.
6. rst_i asserted mid-push in RUN -> state_o=0 and all outputs 0 on the next cycle; counters 0.
